// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: receiver state type and default 640x480 timing constants shared with video_sync_generator
package vga_rx_pkg;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int VS_TIMEOUT_DEF = 420000;
  localparam int ADDR_W_DEF = 19;
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_frame_receiver_sync_edge_detect.sv
// sync_edge_detect: registers the VGA pins once (s1) and flags falling edges of HS, VS and blank_n (s1 vs s2)
module sync_edge_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        blank_n_i,
  input  logic [23:0] bgr_i,
  output logic        blank_n_o,
  output logic [23:0] bgr_o,
  output logic        hs_fall_o,
  output logic        vs_fall_o,
  output logic        blank_fall_o
);
  // {hs, vs, blank_n}; syncs idle high so reset release never looks like an edge
  logic [2:0]  s1_q, s2_q;
  logic [23:0] bgr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q  <= 3'b110;
      s2_q  <= 3'b110;
      bgr_q <= '0;
    end else begin
      s1_q  <= {hs_i, vs_i, blank_n_i};
      s2_q  <= s1_q;
      bgr_q <= bgr_i;
    end
  assign {hs_fall_o, vs_fall_o, blank_fall_o} = ~s1_q & s2_q;
  assign blank_n_o = s1_q[0];
  assign bgr_o = bgr_q;
endmodule

// File: rtl/vga_frame_receiver.sv
// vga_frame_receiver: recovers pixel position from VGA timing, locks on matching frames and emits linear frame-buffer writes
module vga_frame_receiver import vga_rx_pkg::*; #(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int VS_TIMEOUT  = VS_TIMEOUT_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              HS,
  input  logic              VS,
  input  logic              blank_n,
  input  logic [23:0]       bgr_in,
  output logic              locked,
  output logic              frame_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [9:0]        meas_h,
  output logic [9:0]        meas_v,
  output logic              sync_err
);
  localparam logic [ADDR_W-1:0] PIX = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam int WD_W  = $clog2(VS_TIMEOUT + 1);
  localparam int CNT_W = $clog2(LOCK_FRAMES + 1);
  logic              blank_s1, hs_fall, vs_fall, blank_fall;
  logic [23:0]       bgr_s1;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [9:0]        x_q, x_d, y_q, y_d, w_q, w_d, x_base, meas_h_q, meas_v_q;
  logic [ADDR_W-1:0] addr_q, addr_d, a_base, wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              bad_q, bad_d, ovf_q, ovf_d, wr_en_q, wr_en_d, fs_q, err_q, err_d;
  logic              line_end, pix_ok, good, wd_sat, timeout;
  sync_edge_detect u_sync (
    .clk          (vga_clk),
    .rst          (reset),
    .hs_i         (HS),
    .vs_i         (VS),
    .blank_n_i    (blank_n),
    .bgr_i        (bgr_in),
    .blank_n_o    (blank_s1),
    .bgr_o        (bgr_s1),
    .hs_fall_o    (hs_fall),
    .vs_fall_o    (vs_fall),
    .blank_fall_o (blank_fall)
  );
  always_comb begin
    // a line whose blanking never drops is still closed by its HS edge
    line_end  = (blank_fall | (hs_fall & |x_q)) & ~vs_fall;
    x_base    = (vs_fall | line_end) ? '0 : x_q;
    x_d       = blank_s1 ? sat_inc10(x_base) : x_base;
    y_d       = vs_fall ? '0 : line_end ? sat_inc10(y_q) : y_q;
    w_d       = line_end ? x_q : w_q;
    bad_d     = ~vs_fall & (bad_q | (line_end & (x_q != 10'(H_ACTIVE))));
    a_base    = vs_fall ? '0 : addr_q;
    pix_ok    = blank_s1 & (a_base < PIX);
    addr_d    = pix_ok ? a_base + ADDR_W'(1) : a_base;
    ovf_d     = (~vs_fall & ovf_q) | (blank_s1 & ~pix_ok);
    good      = (y_q == 10'(V_ACTIVE)) & ~bad_q & ~ovf_q;
    wd_sat    = wd_q == WD_W'(VS_TIMEOUT);
    timeout   = wd_sat & ~vs_fall;
    wd_d      = vs_fall ? '0 : wd_sat ? wd_q : wd_q + WD_W'(1);
    wr_en_d   = (state_q == LOCKED) & pix_ok;
    wr_addr_d = wr_en_d ? a_base : wr_addr_q;
    wr_data_d = wr_en_d ? bgr_s1 : wr_data_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      cnt_d   = '0;
    end else if (vs_fall && state_q == SEARCH) begin
      state_d = MEASURE;
      cnt_d   = '0;
    end else if (vs_fall && state_q == MEASURE) begin
      cnt_d   = good ? cnt_q + CNT_W'(1) : '0;
      state_d = (good && cnt_q == CNT_W'(LOCK_FRAMES - 1)) ? LOCKED : MEASURE;
    end else if (vs_fall && state_q == LOCKED && !good) begin
      state_d = MEASURE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      state_q   <= SEARCH;
      cnt_q     <= '0;
      wd_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
      meas_h_q  <= '0;
      meas_v_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      addr_q    <= addr_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fs_q      <= vs_fall;
      err_q     <= err_d;
      meas_h_q  <= vs_fall ? w_q : meas_h_q;
      meas_v_q  <= vs_fall ? y_q : meas_v_q;
    end
  assign locked      = state_q == LOCKED;
  assign frame_start = fs_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign meas_h      = meas_h_q;
  assign meas_v      = meas_v_q;
  assign sync_err    = err_q;
endmodule

// File: tb/tb_vga_frame_receiver.sv
// tb_vga_frame_receiver: scaled-down timing source with a frame-level lock model and write/frame scoreboards
module tb_vga_frame_receiver;
  localparam int H = 8, V = 6, LOCK = 2, TO = 200, AW = 6, PIX = H * V, LT = 14;
  logic clk = 1'b0, rst = 1'b1, HS = 1'b1, VS = 1'b1, blank_n = 1'b0;
  logic [23:0] bgr_in = '0;
  logic locked, frame_start, wr_en, sync_err;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [9:0] meas_h, meas_v;
  vga_frame_receiver #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK), .VS_TIMEOUT(TO), .ADDR_W(AW)) dut (
    .vga_clk(clk), .reset(rst), .HS(HS), .VS(VS), .blank_n(blank_n), .bgr_in(bgr_in),
    .locked(locked), .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .meas_h(meas_h), .meas_v(meas_v), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  typedef struct { int addr; logic [23:0] data; } wr_t;
  typedef struct { int w; int lines; bit err; bit lk; } fr_t;
  wr_t wq[$];
  fr_t fq[$];
  int errors = 0, checks = 0;
  int cur_w = 0, cur_lines = 0, cur_pix = 0, m_cnt = 0;
  bit cur_bad = 0, m_search = 1, m_locked = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    wr_t e;
    fr_t f;
    if (!rst) begin
      if (wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", longint'(wr_addr), e.addr);
          chk("wr_data", longint'(wr_data), longint'(e.data));
        end
      end
      if (frame_start) begin
        if (fq.size() == 0) chk("frame_start_unexpected", 1, 0);
        else begin
          f = fq.pop_front();
          chk("meas_h", longint'(meas_h), f.w);
          chk("meas_v", longint'(meas_v), f.lines);
          chk("sync_err", longint'(sync_err), longint'(f.err));
          chk("locked_at_frame", longint'(locked), longint'(f.lk));
        end
      end else if (sync_err) chk("sync_err_stray", 1, 0);
    end
  end
  // frame-level rule: a frame is good when it had V lines of H pixels each
  task automatic model_vs();
    bit good, err;
    fr_t f;
    good = cur_lines == V && !cur_bad && cur_pix <= PIX;
    err = 0;
    if (m_search) begin
      m_search = 0;
      m_cnt = 0;
    end else if (m_locked) begin
      if (!good) begin
        m_locked = 0;
        m_cnt = 0;
        err = 1;
      end
    end else begin
      m_cnt = good ? m_cnt + 1 : 0;
      m_locked = m_cnt >= LOCK;
    end
    f.w = cur_w; f.lines = cur_lines; f.err = err; f.lk = m_locked;
    fq.push_back(f);
    cur_lines = 0; cur_bad = 0; cur_pix = 0;
  endtask
  task automatic drive(input logic h, input logic v, input logic b, input logic [23:0] d);
    HS = h; VS = v; blank_n = b; bgr_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_mid();
    rst = 1'b1;
    #1;
    chk("reset_wr_en", longint'(wr_en), 0);
    chk("reset_locked", longint'(locked), 0);
    wq.delete();
    m_search = 1; m_locked = 0; m_cnt = 0;
    cur_w = 0; cur_lines = 0; cur_pix = 0; cur_bad = 0;
    HS = 1'b1; VS = 1'b1; blank_n = 1'b0; bgr_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic frame(input int nlines, input int short_idx, input int abort_pix);
    logic [23:0] d;
    wr_t e;
    for (int c = 0; c < LT; c++) begin
      if (c == 0) model_vs();
      drive(c >= 2, 1'b0, 1'b0, 24'h0);
    end
    for (int c = 0; c < LT; c++) drive(c >= 2, 1'b1, 1'b0, 24'h0);
    for (int l = 0; l < nlines; l++) begin
      int w;
      w = (l == short_idx) ? H - 1 : H;
      for (int c = 0; c < LT; c++) begin
        bit act;
        act = (c >= 4) && (c < 4 + w);
        d = 24'h0;
        if (act) begin
          if (cur_pix == abort_pix) begin
            reset_mid();
            return;
          end
          d = (l == 2 && c == 4 + 5) ? 24'h000ABC : 24'($urandom);
          if (m_locked && cur_pix < PIX) begin
            e.addr = cur_pix;
            e.data = d;
            wq.push_back(e);
          end
          cur_pix++;
        end
        drive(c >= 2, 1'b1, act, d);
      end
      cur_lines++;
      cur_w = w;
      if (w != H) cur_bad = 1;
    end
    for (int c = 0; c < LT; c++) drive(c >= 2, 1'b1, 1'b0, 24'h0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", longint'(locked), 0);
    chk("rst_wr_en", longint'(wr_en), 0);
    chk("rst_frame_start", longint'(frame_start), 0);
    chk("rst_sync_err", longint'(sync_err), 0);
    chk("rst_meas_h", longint'(meas_h), 0);
    chk("rst_meas_v", longint'(meas_v), 0);
    chk("rst_wr_addr", longint'(wr_addr), 0);
    chk("rst_wr_data", longint'(wr_data), 0);
    repeat (4) frame(V, -1, -1);
    frame(V, 3, -1);
    repeat (2) frame(V, -1, -1);
    frame(V + 1, -1, -1);
    repeat (3) frame(V, -1, -1);
    repeat (TO + 60) drive(1'b1, 1'b1, 1'b0, 24'h0);
    chk("timeout_locked", longint'(locked), 0);
    m_search = 1; m_locked = 0; m_cnt = 0;
    repeat (3) frame(V, -1, -1);
    frame(V, -1, 20);
    repeat (4) frame(V, -1, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("wr_queue_drained", wq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
